// File: rtl/config_pkg.sv
// Shared LSU/memory-side types for the DDR request path.
// ddr_req_t is the queued unit: one LSU beat, write or read.
package config_pkg;

    localparam int unsigned DDR_ADDR_W = 32;
    localparam int unsigned DDR_DATA_W = 32;

    typedef logic [DDR_ADDR_W-1:0] ddr_address_t;
    typedef logic [DDR_DATA_W-1:0] ddr_data_t;

    typedef struct packed {
        logic         is_write;
        ddr_address_t address;
        ddr_data_t    data;
    } ddr_req_t;

    function automatic ddr_req_t make_req(input logic is_write, input ddr_address_t address,
                                          input ddr_data_t data);
        ddr_req_t r;
        r.is_write = is_write;
        r.address  = address;
        r.data     = data;
        return r;
    endfunction

endpackage

// File: rtl/ddr_req_fifo.sv
// Synchronous FIFO of request entries; head visible the cycle after push.
// A pop and a push in the same cycle on a full FIFO are both honoured.
module ddr_req_fifo
    import config_pkg::*;
#(
    parameter int unsigned Depth  = 4,
    parameter type         elem_t = ddr_req_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  elem_t                  data_i,
    input  logic                   pop_i,
    output elem_t                  data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    elem_t             mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]   level_q, level_d;
    logic              do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LvlW'(Depth));
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointers are PtrW bits wide, so a power-of-two depth wraps for free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ddr_request_bridge.sv
// Queues LSU read/write beats and issues them in order on an Avalon-MM master.
// Command held stable under waitrequest; reads throttled by the outstanding limit.
module ddr_request_bridge
    import config_pkg::*;
#(
    parameter int unsigned ReqFifoDepth        = 4,
    parameter int unsigned MaxOutstandingReads = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  ddr_address_t ddr_address_i,
    input  logic         ddr_w_en_i,
    input  ddr_data_t    ddr_w_data_i,
    input  logic         ddr_r_en_i,
    output logic         ddr_w_done_o,
    output ddr_data_t    ddr_r_data_o,
    output logic         ddr_r_valid_o,
    output ddr_address_t avm_address_o,
    output logic         avm_read_o,
    output logic         avm_write_o,
    output ddr_data_t    avm_writedata_o,
    input  logic         avm_waitrequest_i,
    input  ddr_data_t    avm_readdata_i,
    input  logic         avm_readdatavalid_i,
    output logic         busy_o,
    output logic         error_o
);

    localparam int unsigned CntW = $clog2(MaxOutstandingReads) + 1;
    localparam int unsigned LvlW = $clog2(ReqFifoDepth) + 1;

    ddr_req_t        enq_req, head;
    logic            fifo_full, fifo_empty;
    logic [LvlW-1:0] fifo_level, level_next;

    logic            req_any, req_both, push, push_ok, drop;
    logic            present, accept, rd_inc, rd_dec, rdv_spurious;

    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            error_q, error_d;
    logic            busy_q, busy_d;
    logic            w_done_q, r_valid_q;
    ddr_data_t       r_data_q;

    // A simultaneous read is discarded; the write wins.
    assign req_any  = ddr_w_en_i || ddr_r_en_i;
    assign req_both = ddr_w_en_i && ddr_r_en_i;
    assign enq_req  = make_req(ddr_w_en_i, ddr_address_i, ddr_w_data_i);

    assign present = !rst_i && !fifo_empty &&
                     (head.is_write || (out_cnt_q < CntW'(MaxOutstandingReads)));
    assign accept  = present && !avm_waitrequest_i;

    assign push    = !rst_i && req_any;
    assign push_ok = push && (!fifo_full || accept);
    assign drop    = push && !push_ok;

    assign rd_inc       = accept && !head.is_write;
    assign rdv_spurious = avm_readdatavalid_i && (out_cnt_q == '0);
    assign rd_dec       = avm_readdatavalid_i && !rdv_spurious;

    ddr_req_fifo #(
        .Depth  (ReqFifoDepth),
        .elem_t (ddr_req_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (enq_req),
        .pop_i   (accept),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({rd_inc, rd_dec})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // busy reflects the state that will hold after this edge, not last cycle's.
    assign level_next = fifo_level + LvlW'(push_ok) - LvlW'(accept);
    assign busy_d     = (level_next != '0) || (out_cnt_d != '0);
    assign error_d    = error_q || req_both || drop || rdv_spurious;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt_q <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            w_done_q  <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            w_done_q  <= accept && head.is_write;
            r_valid_q <= rd_dec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_dec) r_data_q <= avm_readdata_i;
    end

    assign avm_read_o      = present && !head.is_write;
    assign avm_write_o     = present && head.is_write;
    assign avm_address_o   = head.address;
    assign avm_writedata_o = head.data;

    assign ddr_w_done_o  = w_done_q;
    assign ddr_r_valid_o = r_valid_q;
    assign ddr_r_data_o  = r_data_q;
    assign busy_o        = busy_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_ddr_request_bridge.sv
// Directed and random stimulus for ddr_request_bridge, checked every cycle
// against a queue-level transaction model; the bench also plays the memory.
module tb_ddr_request_bridge;
    import config_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXRD = 8;

    logic         clk = 1'b0;
    logic         rst, w_en, r_en, waitreq, rdv;
    ddr_address_t addr;
    ddr_data_t    wdata, rdata;

    logic         w_done, r_valid, avm_read, avm_write, busy, error;
    ddr_data_t    r_data, avm_wdata;
    ddr_address_t avm_addr;

    always #5 clk = ~clk;

    ddr_request_bridge dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ddr_address_i       (addr),
        .ddr_w_en_i          (w_en),
        .ddr_w_data_i        (wdata),
        .ddr_r_en_i          (r_en),
        .ddr_w_done_o        (w_done),
        .ddr_r_data_o        (r_data),
        .ddr_r_valid_o       (r_valid),
        .avm_address_o       (avm_addr),
        .avm_read_o          (avm_read),
        .avm_write_o         (avm_write),
        .avm_writedata_o     (avm_wdata),
        .avm_waitrequest_i   (waitreq),
        .avm_readdata_i      (rdata),
        .avm_readdatavalid_i (rdv),
        .busy_o              (busy),
        .error_o             (error)
    );

    // Reference model: pending requests, reads in flight, expected outputs.
    ddr_req_t     mq[$];
    ddr_address_t inflight[$];
    int           m_out;
    bit           m_err, m_wdone, m_rvalid, m_busy;
    ddr_data_t    m_rdata;

    int total = 0;
    int bad   = 0;
    int wr_acc = 0, rd_acc = 0, wdone_cnt = 0, rvalid_cnt = 0;
    bit auto_mem = 1'b0, spur_en = 1'b0;
    int rsp_pct = 50;

    function automatic ddr_data_t mem_f(input ddr_address_t a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, compare DUT to model, advance model.
    task automatic cyc();
        bit       pres, acc;
        ddr_req_t hd;
        hd = '0;
        if (auto_mem) begin
            rdv = 1'b0;
            rdata = $urandom;
            if (inflight.size() > 0 && $urandom_range(99) < rsp_pct) begin
                rdv = 1'b1;
                rdata = mem_f(inflight[0]);
            end else if (inflight.size() == 0 && spur_en && $urandom_range(99) == 0) begin
                rdv = 1'b1;
            end
        end
        #1;
        if (mq.size() > 0) hd = mq[0];
        pres = !rst && mq.size() > 0 && (hd.is_write || m_out < MAXRD);
        chk("avm_read", avm_read, pres && !hd.is_write);
        chk("avm_write", avm_write, pres && hd.is_write);
        if (pres) chk("avm_address", avm_addr, hd.address);
        if (pres && hd.is_write) chk("avm_writedata", avm_wdata, hd.data);
        chk("w_done", w_done, m_wdone);
        chk("r_valid", r_valid, m_rvalid);
        if (m_rvalid) chk("r_data", r_data, m_rdata);
        chk("busy", busy, m_busy);
        chk("error", error, m_err);
        if (avm_write && !waitreq) wr_acc++;
        if (avm_read && !waitreq)  rd_acc++;
        if (w_done)  wdone_cnt++;
        if (r_valid) rvalid_cnt++;
        acc = pres && !waitreq;

        @(posedge clk);
        if (rst) begin
            mq.delete();
            inflight.delete();
            m_out = 0;
            m_err = 0;
            m_wdone = 0;
            m_rvalid = 0;
            m_busy = 0;
        end else begin
            m_wdone  = acc && hd.is_write;
            m_rvalid = rdv && m_out > 0;
            if (m_rvalid) m_rdata = rdata;
            if (rdv) begin
                if (m_out == 0) m_err = 1;
                else begin
                    m_out--;
                    void'(inflight.pop_front());
                end
            end
            if (acc) begin
                void'(mq.pop_front());
                if (!hd.is_write) begin
                    m_out++;
                    inflight.push_back(hd.address);
                end
            end
            if (w_en && r_en) m_err = 1;
            if (w_en || r_en) begin
                if (mq.size() < DEPTH) mq.push_back(make_req(w_en, addr, wdata));
                else m_err = 1;
            end
            m_busy = (mq.size() != 0) || (m_out != 0);
        end
        @(negedge clk);
    endtask

    task automatic req(input logic w, input logic r, input ddr_address_t a, input ddr_data_t d);
        w_en = w; r_en = r; addr = a; wdata = d;
        cyc();
        w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int b0, b1, p;
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; waitreq = 1'b0; rdv = 1'b0;
        addr = '0; wdata = '0; rdata = '0;
        m_out = 0; m_err = 0; m_wdone = 0; m_rvalid = 0; m_busy = 0; m_rdata = '0;
        @(negedge clk);
        run(2);
        rst = 1'b0;

        // Single read to 0x10, data returned two cycles after accept.
        req(1'b0, 1'b1, 32'h10, 32'h0);
        cyc();
        cyc();
        rdv = 1'b1; rdata = 32'hABCD;
        cyc();
        rdv = 1'b0;
        chk("single_rd_valid", r_valid, 1'b1);
        chk("single_rd_data", r_data, 32'hABCD);
        cyc();
        chk("single_rd_busy", busy, 1'b0);

        // Four writes under a three-cycle stall.
        b0 = wdone_cnt;
        waitreq = 1'b1;
        for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 32'h100 + i, $urandom);
        waitreq = 1'b0;
        run(6);
        chk("stall_wdone_cnt", wdone_cnt - b0, 4);
        chk("stall_error", error, 1'b0);

        // Six writes against a stalled memory: two dropped.
        b0 = wr_acc;
        waitreq = 1'b1;
        for (int i = 0; i < 6; i++) req(1'b1, 1'b0, 32'h200 + i, $urandom);
        chk("ovf_error", error, 1'b1);
        waitreq = 1'b0;
        run(6);
        chk("ovf_writes", wr_acc - b0, 4);
        do_reset();

        // Nine reads with no data returning: limit of eight.
        b0 = rd_acc;
        b1 = rvalid_cnt;
        for (int i = 0; i < 9; i++) req(1'b0, 1'b1, 32'h300 + 4 * i, 32'h0);
        run(3);
        chk("max_rd_accepted", rd_acc - b0, 8);
        chk("max_rd_read_low", avm_read, 1'b0);
        rdv = 1'b1; rdata = mem_f(32'h300);
        cyc();
        rdv = 1'b0;
        #1;
        chk("max_rd_9th_issue", avm_read, 1'b1);
        auto_mem = 1'b1; rsp_pct = 100;
        run(15);
        auto_mem = 1'b0; rdv = 1'b0;
        chk("max_rd_returned", rvalid_cnt - b1, 9);
        chk("max_rd_idle", busy, 1'b0);

        // Write and read together: only the write goes out.
        b0 = wr_acc;
        b1 = rd_acc;
        req(1'b1, 1'b1, 32'h400, 32'hCAFE_0001);
        run(3);
        chk("both_wr", wr_acc - b0, 1);
        chk("both_rd", rd_acc - b1, 0);
        chk("both_error", error, 1'b1);
        do_reset();

        // Spurious readdatavalid while idle.
        b1 = rvalid_cnt;
        rdv = 1'b1; rdata = 32'hDEAD;
        cyc();
        rdv = 1'b0;
        cyc();
        chk("spur_no_valid", rvalid_cnt - b1, 0);
        chk("spur_error", error, 1'b1);
        do_reset();

        // Reset with three reads outstanding.
        for (int i = 0; i < 3; i++) req(1'b0, 1'b1, 32'h500 + 4 * i, 32'h0);
        run(2);
        chk("rst3_busy_before", busy, 1'b1);
        do_reset();
        chk("rst3_busy_after", busy, 1'b0);
        rdv = 1'b1; rdata = 32'h1234;
        cyc();
        rdv = 1'b0;
        cyc();
        chk("rst3_late_rdv_error", error, 1'b1);
        do_reset();

        // Random traffic.
        auto_mem = 1'b1; spur_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) rsp_pct = $urandom_range(20, 90);
            p = $urandom_range(99);
            rst     = ($urandom_range(299) == 0);
            w_en    = (p < 25);
            r_en    = (p >= 22 && p < 47);
            addr    = $urandom;
            wdata   = $urandom;
            waitreq = ($urandom_range(99) < 30);
            cyc();
        end
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; waitreq = 1'b0;
        spur_en = 1'b0; rsp_pct = 100;
        run(40);
        chk("drain_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_request_bridge.md
DDR_REQUEST_BRIDGE -- requirements
Module: ddr_request_bridge

Interface
REQ-001 Parameter ReqFifoDepth, default 4: request-FIFO entries; power of two, at least 2.
REQ-002 Parameter MaxOutstandingReads, default 8: maximum number of reads accepted by memory but not yet returned.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 ddr_address_i  in  ddr_address_t  LSU-side request address.
REQ-006 ddr_w_en_i  in  1  LSU-side write request; one-cycle pulse per beat.
REQ-007 ddr_w_data_i  in  ddr_data_t  LSU-side write data.
REQ-008 ddr_r_en_i  in  1  LSU-side read request; one-cycle pulse per beat.
REQ-009 ddr_w_done_o  out  1  pulse: one write accepted by memory.
REQ-010 ddr_r_data_o  out  ddr_data_t  returned read data.
REQ-011 ddr_r_valid_o  out  1  pulse: ddr_r_data_o is valid.
REQ-012 avm_address_o  out  ddr_address_t  memory-side address.
REQ-013 avm_read_o  out  1  memory-side read command.
REQ-014 avm_write_o  out  1  memory-side write command.
REQ-015 avm_writedata_o  out  ddr_data_t  memory-side write data.
REQ-016 avm_waitrequest_i  in  1  memory stall; when high, the current command is not accepted.
REQ-017 avm_readdata_i  in  ddr_data_t  memory read data.
REQ-018 avm_readdatavalid_i  in  1  memory read data valid; responses return in order.
REQ-019 busy_o  out  1  high while the FIFO is non-empty or any read is outstanding.
REQ-020 error_o  out  1  sticky protocol-error flag.

Function
REQ-021 A cycle with ddr_w_en_i or ddr_r_en_i high shall enqueue one entry {is_write, address, data} into the FIFO in that cycle.
REQ-022 Simultaneous ddr_w_en_i and ddr_r_en_i: enqueue the write only, drop the read, set error_o.
REQ-023 A request arriving while the FIFO is full: drop it, set error_o, leave the FIFO contents unchanged.
REQ-024 FIFO head presentation:
  - Write head: presented on avm_* whenever the FIFO is non-empty.
  - Read head: presented only while the outstanding count is below MaxOutstandingReads.
  - Earliest presentation is the cycle after enqueue.
REQ-025 avm_address_o, avm_writedata_o, avm_read_o and avm_write_o shall stay stable while avm_waitrequest_i is high.
REQ-026 A command is accepted in any cycle where it is presented and avm_waitrequest_i is low; accept dequeues the head.
  - Consecutive accepts are allowed, giving one beat per cycle.
REQ-027 Accepted write: ddr_w_done_o pulses for exactly one cycle, in the cycle after acceptance.
REQ-028 Accepted read: the outstanding counter increments.
REQ-029 avm_readdatavalid_i high: the counter decrements; ddr_r_data_o/ddr_r_valid_o are registered out one cycle later.
REQ-030 Counter increment and decrement in the same cycle leave the counter unchanged.
REQ-031 avm_readdatavalid_i while the counter is 0: the data is dropped, ddr_r_valid_o stays low, and error_o is set.
REQ-032 Commands issue strictly in enqueue order; reads are never reordered around writes.
REQ-033 An enqueue and a dequeue in the same cycle on a full FIFO is a dequeue-then-enqueue: no drop and no error.
REQ-034 The outstanding counter is $clog2(MaxOutstandingReads)+1 bits wide; FIFO pointers wrap modulo ReqFifoDepth.
REQ-035 busy_o and error_o are registered outputs.

Reset
REQ-036 While rst_i is high:
  - FIFO emptied and outstanding counter cleared to 0.
  - error_o cleared to 0.
  - All avm_* command strobes, ddr_w_done_o, ddr_r_valid_o and busy_o driven 0.
REQ-037 Reset asserted mid-operation discards queued and in-flight requests.
  - Any later avm_readdatavalid_i for a discarded read is handled per REQ-031.
REQ-038 Datapath registers (data and address) need no reset.

Structure
REQ-039 ddr_address_t and ddr_data_t shall come from config_pkg.
REQ-040 A new packed struct ddr_req_t {is_write, address, data} shall be added to config_pkg.
REQ-041 The FIFO shall be a separate sub-module ddr_req_fifo, parameterised by depth and element type ddr_req_t, with push, pop, full and empty ports.

Verification
REQ-042 Single read to 0x10 with waitrequest low and readdata 0xABCD two cycles after accept:
  - avm_read_o is high in cycle N+1.
  - ddr_r_valid_o pulses with 0xABCD.
  - busy_o returns to 0.
REQ-043 Four back-to-back writes with waitrequest held high for 3 cycles:
  - Command stays stable during the stall.
  - Four ddr_w_done_o pulses occur, in order, on the following cycles.
  - error_o stays 0.
REQ-044 Six writes with waitrequest held high (depth 4): the 5th and 6th are dropped, error_o=1, and exactly 4 writes reach memory.
REQ-045 Nine reads with readdatavalid withheld (MaxOutstandingReads=8):
  - Exactly 8 reads are accepted.
  - avm_read_o drops while the 9th waits.
  - The 9th issues in the cycle after the first readdatavalid.
REQ-046 Corner cases:
  - w_en and r_en asserted together: only the write is issued, error_o=1.
  - Spurious readdatavalid while idle: no ddr_r_valid_o, error_o=1.
  - Reset asserted with 3 reads outstanding: counter 0 and busy_o 0 next cycle.
